down_counter: RTL
=================

# down_counter

Loadable down-counter/timer that is the complement of the team's free-running 4-bit up-counter. It counts down from a loaded value to zero and flags expiry with a one-cycle terminal-count pulse. It can optionally reload and run periodically. It sits beside the up-counter wherever a bounded delay, timeout or periodic tick is required.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `load`  in  1: start request; samples `load_value`.
- `load_value`  in  WIDTH: start value, unsigned.
- `enable`  in  1: count-enable while running; deassertion pauses.
- `abort`  in  1: stop immediately, holding the current count.
- `auto_reload`  in  1: periodic mode select; only effective when `DOWN_COUNTER_RELOAD_EN` is defined.
- `count`  out  WIDTH: current count, registered.
- `busy`  out  1: high while in RUN.
- `zero`  out  1: `count == 0`, decoded from the register with no extra latency.
- `tc_pulse`  out  1: registered, high for exactly one cycle on expiry.

## Operation
- States:
  - IDLE: count holds.
  - RUN: count decrements on each cycle with `enable`=1.
- `reset` asserted, at any time and in any state, with no clock needed:
  - state goes to IDLE;
  - `count`, the internal `reload_val` register, `busy` and `tc_pulse` all go to 0;
  - `zero` reads 1.
- Priority per cycle, highest first: `abort`, then `load`, then the count step.
- `abort`, in any state:
  - next state is IDLE and `count` holds;
  - `tc_pulse`=0;
  - a simultaneous `load` is ignored.
- `load` with `load_value` != 0, in any state:
  - `count` and `reload_val` take `load_value`;
  - next state is RUN and `tc_pulse`=0;
  - a load during RUN restarts the count.
- `load` with `load_value` == 0:
  - `count`=0, next state is IDLE;
  - `tc_pulse`=1 on the next cycle, which is immediate expiry;
  - no reload ever happens from a zero value.
- RUN, `enable`=1, `count` > 1: `count` decrements by 1.
- RUN, `enable`=1, `count` == 1, this is expiry and `tc_pulse`=1 next cycle:
  - if reload is active, `count` takes `reload_val` and the state stays RUN;
  - otherwise `count` goes to 0 and the state goes to IDLE.
- RUN, `enable`=0: `count` holds, state stays RUN, `busy` stays 1.
- IDLE: `enable` is ignored.
- Arithmetic: unsigned, WIDTH bits. No wrap below 0 is possible, because the count never decrements from 0.

## Timing
- Latency from `load` to `count`: 1 cycle.
- A load of N, with `enable` held, gives `tc_pulse` in the Nth cycle after the load edge. `count` reads 0 in the same cycle that `tc_pulse` is high (non-reload case).
- `tc_pulse` is never high for two consecutive cycles except in these cases:
  - reload mode with `reload_val` == 1, which pulses every cycle;
  - back-to-back zero loads.
- Reload mode: the period is `reload_val` cycles of asserted `enable`, with no dead cycle at the wrap.
- `busy` falls in the same cycle as the non-reload `tc_pulse`, and in the cycle after `abort`.

## Configuration
- `DOWN_COUNTER_RELOAD_EN` defined:
  - the `auto_reload` input is honoured as described in Operation;
  - the `reload_val` register is present.
- Not defined:
  - `auto_reload` is ignored and every expiry returns to IDLE;
  - `reload_val` is not built;
  - all other behaviour is identical.

## Test plan
- Reset mid-RUN:
  - stimulus: load 9, assert `reset` asynchronously after 3 counts;
  - required: `count`=0, `busy`=0, `zero`=1 immediately, before the next `clk` edge.
- One-shot:
  - stimulus: WIDTH=4, load 5, `enable`=1;
  - required: `count` reads 5,4,3,2,1,0;
  - required: `tc_pulse` is a single pulse coincident with 0; `busy` ends at 0.
- Pause and abort:
  - stimulus: load 15, hold `enable`=0 for 4 cycles;
  - required: `count` stays 15;
  - stimulus: then abort while `count`=12 with `load` also high;
  - required: IDLE with `count`=12.
- Zero and max:
  - stimulus: load 0;
  - required: one `tc_pulse`, IDLE;
  - stimulus: load 15;
  - required: `tc_pulse` exactly 15 cycles later.
- Reload, macro defined:
  - stimulus: load 3 with `auto_reload`=1;
  - required: `tc_pulse` every 3 cycles, `count` sequence 3,2,1,3,2,1, `busy` stays 1.
- Reload, macro undefined:
  - stimulus: same as above;
  - required: a single pulse, then IDLE.
- Restart:
  - stimulus: load 7, then load 2 when `count`=4;
  - required: `count` reads 2,1,0, with `tc_pulse` 2 cycles after the second load.

Source files
------------

// File: rtl/down_counter.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse on expiry.
// Define DOWN_COUNTER_RELOAD_EN to build the reload register and honour auto_reload.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             tc_pulse
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             reload_act;
  logic [WIDTH-1:0] reload_src;

`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] reload_nxt;

  assign reload_act = auto_reload;
  assign reload_src = reload_val;
`else
  logic unused_auto_reload;

  assign unused_auto_reload = auto_reload;
  assign reload_act         = 1'b0;
  assign reload_src         = '0;
`endif

  // Next-state decode: abort beats load, load beats the count step.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_nxt = reload_val;
`endif
    if (abort) begin
      state_nxt = IDLE;
    end else if (load) begin
      count_nxt = load_value;
      if (load_value == '0) begin
        // A zero load expires at once and never arms a reload.
        state_nxt = IDLE;
        tc_nxt    = 1'b1;
      end else begin
        state_nxt = RUN;
`ifdef DOWN_COUNTER_RELOAD_EN
        reload_nxt = load_value;
`endif
      end
    end else if (state == RUN && enable) begin
      if (count > ONE) begin
        count_nxt = count - ONE;
      end else if (count == ONE) begin
        tc_nxt = 1'b1;
        if (reload_act) begin
          count_nxt = reload_src;
        end else begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      tc_pulse <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      tc_pulse <= tc_nxt;
    end
  end

`ifdef DOWN_COUNTER_RELOAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_val <= '0;
    end else begin
      reload_val <= reload_nxt;
    end
  end
`endif

  assign busy = (state == RUN);
  assign zero = (count == '0);

endmodule
